// File: rtl/i2_router_pkg.sv
// rtl/i2_router_pkg.sv - shared flit type codes and read-controller state encoding
//
// Purpose : flit type-field definitions shared by the router FIFO read and
//           write controllers, plus the read-controller state type.
// Ports   : none (package).

package i2_router_pkg;

  localparam int FLIT_TYPE_W = 3;

  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD = 3'b001;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL = 3'b110;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PKT  = 1'b1
  } rd_state_t;

  function automatic logic is_head(input logic [FLIT_TYPE_W-1:0] flit_type);
    return flit_type == FLIT_HEAD;
  endfunction

  function automatic logic is_tail(input logic [FLIT_TYPE_W-1:0] flit_type);
    return flit_type == FLIT_TAIL;
  endfunction

endpackage

// File: rtl/i2_router_out_stage.sv
// rtl/i2_router_out_stage.sv - single-entry output staging register with accept logic
//
// Purpose : holds the flit currently offered downstream and decides when it
//           is taken, so the read controller knows when it may load again.
// Ports   : clk, rst_n            clock, async active-low reset
//           load, load_flit,      write a new flit into the stage and the
//           load_sel              port (0 = port1, 1 = port2) it targets
//           output_bussy1/2       downstream back-pressure per port
//           ready                 stage empty or its flit leaves this cycle
//           output_req1/2         flit offered on port1 / port2
//           output_flit           staged flit

module i2_router_out_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_flit,
  input  logic              load_sel,
  input  logic              output_bussy1,
  input  logic              output_bussy2,
  output logic              ready,
  output logic              output_req1,
  output logic              output_req2,
  output logic [DATA_W-1:0] output_flit
);

  logic              out_valid;
  logic              out_sel;
  logic [DATA_W-1:0] out_flit;
  logic              accept;

  assign accept = out_valid && !(out_sel ? output_bussy2 : output_bussy1);
  assign ready  = !out_valid || accept;

  // A load may coincide with an accept; the load wins so throughput stays
  // at one flit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sel   <= 1'b0;
      out_flit  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_sel   <= load_sel;
      out_flit  <= load_flit;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  assign output_req1 = out_valid && !out_sel;
  assign output_req2 = out_valid && out_sel;
  assign output_flit = out_flit;

endmodule

// File: rtl/i2_router_fifo_rdctrl.sv
// rtl/i2_router_fifo_rdctrl.sv - router input FIFO read controller (packet framing and routing)
//
// Purpose : pops flits from a show-ahead FIFO, frames them into packets
//           (head..tail), routes each packet to port1 or port2 from the head
//           flit's destination bit and drops stray body/tail flits.
// Ports   : clk, rst_n            clock, async active-low reset
//           FIFO_empty, FIFO_dout FIFO status and head-of-FIFO flit
//           FIFO_rd               pop strobe (combinational, same cycle)
//           output_req1/2         flit offered on port1 / port2
//           output_flit           offered flit
//           output_bussy1/2       downstream back-pressure
//           drop_cnt              saturating drop counter (optional)
// Options : I2_ROUTER_RDCTRL_ERRCNT_EN adds the drop_cnt output.

module i2_router_fifo_rdctrl
  import i2_router_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEST_BIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              FIFO_empty,
  input  logic [DATA_W-1:0] FIFO_dout,
  output logic              FIFO_rd,
  output logic              output_req1,
  output logic              output_req2,
  output logic [DATA_W-1:0] output_flit,
  input  logic              output_bussy1,
  input  logic              output_bussy2
`ifdef I2_ROUTER_RDCTRL_ERRCNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  rd_state_t state;
  logic      port_q;
  logic      stage_ready;
  logic      top_head;
  logic      top_tail;
  logic      load;
  logic      load_sel;
  logic      discard;
  logic      miss;

  assign top_head = is_head(FIFO_dout[FLIT_TYPE_W-1:0]);
  assign top_tail = is_tail(FIFO_dout[FLIT_TYPE_W-1:0]);

  // rst_n gates the pop decision so nothing leaves the FIFO while reset is held.
  always_comb begin
    load     = 1'b0;
    discard  = 1'b0;
    miss     = 1'b0;
    load_sel = port_q;
    if (rst_n && !FIFO_empty) begin
      if (state == RD_IDLE) begin
        if (top_head) begin
          load     = stage_ready;
          load_sel = FIFO_dout[DEST_BIT];
        end else begin
          // Orphan body/tail: dropped without waiting on the stage.
          discard = 1'b1;
        end
      end else begin
        if (top_head) begin
          // Tail went missing: end this packet, leave the head for IDLE.
          miss = 1'b1;
        end else begin
          load = stage_ready;
        end
      end
    end
  end

  assign FIFO_rd = load || discard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RD_IDLE;
      port_q <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (load) begin
            state  <= RD_PKT;
            port_q <= FIFO_dout[DEST_BIT];
          end
        end
        RD_PKT: begin
          if (miss || (load && top_tail)) begin
            state <= RD_IDLE;
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  i2_router_out_stage #(
    .DATA_W(DATA_W)
  ) u_out_stage (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .load_flit     (FIFO_dout),
    .load_sel      (load_sel),
    .output_bussy1 (output_bussy1),
    .output_bussy2 (output_bussy2),
    .ready         (stage_ready),
    .output_req1   (output_req1),
    .output_req2   (output_req2),
    .output_flit   (output_flit)
  );

`ifdef I2_ROUTER_RDCTRL_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'h00;
    end else if ((discard || miss) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule
